// File: rtl/nasti_lite_bram_arbiter_pkg.sv
// Shared constants and helpers for the NASTI-lite BRAM arbiter.
// Supports up to eight requesters, so requester ids fit in three bits.
package nasti_lite_bram_arbiter_pkg;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_ID_W = 3;

    // Encodes a one-hot (or zero) grant vector to a requester index.
    function automatic logic [MAX_ID_W-1:0] onehot_to_id(input logic [MAX_REQ-1:0] oh);
        logic [MAX_ID_W-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                id = id | MAX_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/nasti_lite_bram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 and wraps,
// granting the first eligible requester. The grant is one-hot, or zero when nobody is eligible.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!found && eligible[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nasti_lite_bram_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM among NUM_REQ requesters with round-robin
// arbitration. Each requester gets one response per request, through a one-entry buffer.
module nasti_lite_bram_arbiter
    import nasti_lite_bram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BRAM_ADDR_WIDTH = 16
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_we,
    input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wrdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [NUM_REQ-1:0]                   rsp_write,
    output logic [NUM_REQ*DATA_WIDTH-1:0]        rsp_rddata,
    output logic                                 bram_en,
    output logic [DATA_WIDTH/8-1:0]              bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
    output logic [DATA_WIDTH-1:0]                bram_wrdata,
    input  logic [DATA_WIDTH-1:0]                bram_rddata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         inflight_hit, outstanding, eligible, rr_grant, grant;
    logic [ID_W-1:0]            last_grant, grant_id, inflight_id;
    logic                       inflight_v, inflight_write;
    logic [NUM_REQ-1:0]         buf_v, buf_write;
    logic [DATA_WIDTH-1:0]      buf_data [NUM_REQ];
    logic [STRB_W-1:0]          sel_we;
    logic [BRAM_ADDR_WIDTH-1:0] sel_addr, addr_q;
    logic [DATA_WIDTH-1:0]      sel_wrdata, wrdata_q, fwd_data;

    // Outstanding status; a draining response frees the requester in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            inflight_hit[i] = inflight_v && (inflight_id == ID_W'(i));
        end
        outstanding = buf_v | inflight_hit;
        rsp_valid   = areset ? '0 : outstanding;
        eligible    = req_valid & (~outstanding | (rsp_valid & rsp_ready));
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (rr_grant)
    );

    assign grant     = areset ? '0 : rr_grant;
    assign req_ready = grant;
    assign grant_id  = ID_W'(onehot_to_id(MAX_REQ'(grant)));

    // Request mux; address and write data hold their last value while idle.
    always_comb begin
        sel_we     = '0;
        sel_addr   = addr_q;
        sel_wrdata = wrdata_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we     = req_we[i*STRB_W +: STRB_W];
                sel_addr   = req_addr[i*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
                sel_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        bram_en     = |grant;
        bram_we     = sel_we;
        bram_addr   = sel_addr;
        bram_wrdata = sel_wrdata;
    end

    // Response side: buffered entry wins, otherwise forward the stage directly.
    always_comb begin
        fwd_data = inflight_write ? '0 : bram_rddata;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_write[i] = buf_v[i] ? buf_write[i] : (inflight_hit[i] & inflight_write);
            rsp_rddata[i*DATA_WIDTH +: DATA_WIDTH] =
                buf_v[i] ? buf_data[i] : (inflight_hit[i] ? fwd_data : '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            inflight_v     <= 1'b0;
            inflight_id    <= '0;
            inflight_write <= 1'b0;
            last_grant     <= ID_W'(NUM_REQ - 1);
            addr_q         <= '0;
            wrdata_q       <= '0;
            buf_v          <= '0;
            buf_write      <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            inflight_v <= |grant;
            if (|grant) begin
                inflight_id    <= grant_id;
                inflight_write <= |sel_we;
                last_grant     <= grant_id;
                addr_q         <= sel_addr;
                wrdata_q       <= sel_wrdata;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (inflight_hit[i] && !rsp_ready[i]) begin
                    buf_v[i]     <= 1'b1;
                    buf_write[i] <= inflight_write;
                    buf_data[i]  <= fwd_data;
                end else if (buf_v[i] && rsp_ready[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

endmodule
